// File: rtl/gamepad_pmod_rx.sv
// gamepad_pmod_rx: receives the three-wire Gamepad PMOD stream (latch, clock, data)
// and commits well-formed 24-bit frames as a two-controller button vector.
// buttons[23:12] = controller 1, buttons[11:0] = controller 2; the first bit after
// a latch lands in buttons[23]. A watchdog clears the buttons when the PMOD is silent.
// Optional feature macro: GAMEPAD_PRESENCE_EN (a 12'hFFF half means controller absent).
module gamepad_pmod_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pmod_latch,
    input  logic        pmod_clk,
    input  logic        pmod_data,
    output logic [23:0] buttons,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        connected
);

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned WD_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(31);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYCLES - 1);

    logic             prev_latch_q, prev_latch_d;
    logic             prev_clk_q,   prev_clk_d;
    logic [23:0]      shreg_q,      shreg_d;
    logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
    logic [WD_W-1:0]  wd_cnt_q,     wd_cnt_d;
    logic [23:0]      buttons_q,    buttons_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q,   frame_err_d;
    logic             connected_q,   connected_d;

    logic        latch_rise_c;
    logic        clk_rise_c;
    logic        commit_c;
    logic [23:0] commit_val_c;
    logic        commit_conn_c;

    // Edge detection; a latch rise takes priority over a coincident clock rise
    always_comb begin
        latch_rise_c = pmod_latch & ~prev_latch_q;
        clk_rise_c   = pmod_clk & ~prev_clk_q & ~latch_rise_c;
        commit_c     = latch_rise_c && (bit_cnt_q == CNT_FRAME);
    end

`ifdef GAMEPAD_PRESENCE_EN
    // An all-ones half means that controller is unplugged: commit it as released
    always_comb begin
        logic hi_absent;
        logic lo_absent;
        hi_absent     = (shreg_q[23:12] == 12'hFFF);
        lo_absent     = (shreg_q[11:0]  == 12'hFFF);
        commit_val_c  = {hi_absent ? 12'h000 : shreg_q[23:12],
                         lo_absent ? 12'h000 : shreg_q[11:0]};
        commit_conn_c = ~(hi_absent & lo_absent);
    end
`else
    // Raw commit; presence is tracked by the watchdog alone
    always_comb begin
        commit_val_c  = shreg_q;
        commit_conn_c = 1'b1;
    end
`endif

    // Next-state: shifting, frame boundary handling and watchdog
    always_comb begin
        prev_latch_d  = pmod_latch;
        prev_clk_d    = pmod_clk;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        buttons_d     = buttons_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        connected_d   = connected_q;
        wd_cnt_d      = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WD_W'(1);

        if (latch_rise_c) begin
            bit_cnt_d = '0;
            if (commit_c) begin
                buttons_d     = commit_val_c;
                frame_valid_d = 1'b1;
                connected_d   = commit_conn_c;
                wd_cnt_d      = '0;
            end else begin
                frame_err_d = 1'b1;
            end
        end else if (clk_rise_c) begin
            shreg_d   = {shreg_q[22:0], pmod_data};
            bit_cnt_d = (bit_cnt_q == CNT_MAX) ? CNT_MAX : bit_cnt_q + CNT_W'(1);
        end

        // Silent PMOD: drop everything once the watchdog saturates
        if (!commit_c && (wd_cnt_d == WD_MAX)) begin
            buttons_d   = '0;
            connected_d = 1'b0;
        end
    end

    // State registers; line history resets high so already-high lines give no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_latch_q  <= 1'b1;
            prev_clk_q    <= 1'b1;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            wd_cnt_q      <= '0;
            buttons_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            connected_q   <= 1'b0;
        end else begin
            prev_latch_q  <= prev_latch_d;
            prev_clk_q    <= prev_clk_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            buttons_q     <= buttons_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            connected_q   <= connected_d;
        end
    end

    assign buttons     = buttons_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign connected   = connected_q;

endmodule

// File: tb/tb_gamepad_pmod_rx.sv
// Bench for gamepad_pmod_rx: table of frames with hand-computed results on a
// long-timeout instance, plus reset and watchdog sequences (second instance, timeout 16).
module tb_gamepad_pmod_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pmod_latch = 1'b0;
    logic        pmod_clk = 1'b0;
    logic        pmod_data = 1'b0;

    logic [23:0] buttons,   w_buttons;
    logic        frame_valid, w_frame_valid;
    logic        frame_err,   w_frame_err;
    logic        connected,   w_connected;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gamepad_pmod_rx #(.TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .pmod_latch(pmod_latch), .pmod_clk(pmod_clk), .pmod_data(pmod_data),
        .buttons(buttons), .frame_valid(frame_valid),
        .frame_err(frame_err), .connected(connected)
    );

    gamepad_pmod_rx #(.TIMEOUT_CYCLES(16)) dut_wd (
        .clk(clk), .rst_n(rst_n),
        .pmod_latch(pmod_latch), .pmod_clk(pmod_clk), .pmod_data(pmod_data),
        .buttons(w_buttons), .frame_valid(w_frame_valid),
        .frame_err(w_frame_err), .connected(w_connected)
    );

    typedef struct {
        int          nclk;
        logic [23:0] data;
        bit          simul;
        bit          exp_valid;
        logic [23:0] exp_btn;
        bit          exp_conn;
    } vec_t;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift n bits, MSB of data first; extra bits beyond 24 are ones
    task automatic shift_bits(input int n, input logic [23:0] data);
        for (int i = 0; i < n; i++) begin
            if (i < 24) pmod_data = data[23-i];
            else        pmod_data = 1'b1;
            pmod_clk = 1'b0;
            tick(); tick();
            pmod_clk = 1'b1;
            tick(); tick();
        end
    endtask

    // Raise latch (optionally together with a clock rise); returns on the result cycle
    task automatic latch_edge(input bit simul);
        if (simul) begin
            pmod_clk = 1'b0;
            tick(); tick();
            pmod_data = 1'b1;
            pmod_clk  = 1'b1;
        end
        pmod_latch = 1'b1;
        tick();
    endtask

    task automatic latch_release();
        tick();
        pmod_latch = 1'b0;
        tick();
    endtask

    vec_t vecs[10];
    logic [23:0] wd_exp;

    initial begin
        // Frame table: {clocks, data, simultaneous edge, valid?, buttons, connected}
        vecs[0] = '{24, 24'hA5C3F0, 1'b0, 1'b1, 24'hA5C3F0, 1'b1};
        vecs[1] = '{23, 24'h123456, 1'b0, 1'b0, 24'hA5C3F0, 1'b1};
        vecs[2] = '{30, 24'hFFFFFF, 1'b0, 1'b0, 24'hA5C3F0, 1'b1};
        vecs[3] = '{24, 24'h000001, 1'b0, 1'b1, 24'h000001, 1'b1};
        vecs[4] = '{24, 24'hABCDEF, 1'b1, 1'b1, 24'hABCDEF, 1'b1};
        vecs[5] = '{24, 24'h0F0F0F, 1'b0, 1'b1, 24'h0F0F0F, 1'b1};
        vecs[6] = '{0,  24'h000000, 1'b0, 1'b0, 24'h0F0F0F, 1'b1};
`ifdef GAMEPAD_PRESENCE_EN
        vecs[7] = '{24, 24'hFFF081, 1'b0, 1'b1, 24'h000081, 1'b1};
        vecs[8] = '{24, 24'hFFFFFF, 1'b0, 1'b1, 24'h000000, 1'b0};
        vecs[9] = '{24, 24'h081FFF, 1'b0, 1'b1, 24'h081000, 1'b1};
        wd_exp  = 24'h000000;
`else
        vecs[7] = '{24, 24'hFFF081, 1'b0, 1'b1, 24'hFFF081, 1'b1};
        vecs[8] = '{24, 24'hFFFFFF, 1'b0, 1'b1, 24'hFFFFFF, 1'b1};
        vecs[9] = '{24, 24'h081FFF, 1'b0, 1'b1, 24'h081FFF, 1'b1};
        wd_exp  = 24'hFFF000;
`endif

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_buttons", buttons, 24'h0);
        chk("rst_valid", 24'(frame_valid), 24'h0);
        chk("rst_err", 24'(frame_err), 24'h0);
        chk("rst_connected", 24'(connected), 24'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Table-driven frames
        for (int v = 0; v < 10; v++) begin
            shift_bits(vecs[v].nclk, vecs[v].data);
            latch_edge(vecs[v].simul);
            chk($sformatf("v%0d_valid", v), 24'(frame_valid), 24'(vecs[v].exp_valid));
            chk($sformatf("v%0d_err", v), 24'(frame_err), 24'(!vecs[v].exp_valid));
            chk($sformatf("v%0d_buttons", v), buttons, vecs[v].exp_btn);
            chk($sformatf("v%0d_connected", v), 24'(connected), 24'(vecs[v].exp_conn));
            latch_release();
            chk($sformatf("v%0d_valid_off", v), 24'(frame_valid), 24'h0);
            chk($sformatf("v%0d_err_off", v), 24'(frame_err), 24'h0);
        end

        // Re-establish a nonzero, connected state, then reset mid-frame
        shift_bits(24, 24'h5A5A5A);
        latch_edge(1'b0);
        chk("pre_rst_buttons", buttons, 24'h5A5A5A);
        latch_release();
        shift_bits(10, 24'hFFFFFF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_buttons", buttons, 24'h0);
        chk("mid_rst_connected", 24'(connected), 24'h0);
        chk("mid_rst_valid", 24'(frame_valid), 24'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        shift_bits(24, 24'h123456);
        latch_edge(1'b0);
        chk("post_rst_valid", 24'(frame_valid), 24'h1);
        chk("post_rst_buttons", buttons, 24'h123456);
        chk("post_rst_connected", 24'(connected), 24'h1);
        latch_release();

        // Watchdog on the timeout-16 instance: clears exactly 15 cycles after commit
        shift_bits(24, 24'hFFF000);
        latch_edge(1'b0);
        chk("wd_commit_valid", 24'(w_frame_valid), 24'h1);
        chk("wd_commit_buttons", w_buttons, wd_exp);
        chk("wd_commit_connected", 24'(w_connected), 24'h1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 1) pmod_latch = 1'b0;
            if (k == 14) begin
                chk("wd_k14_buttons", w_buttons, wd_exp);
                chk("wd_k14_connected", 24'(w_connected), 24'h1);
            end
        end
        chk("wd_k15_buttons", w_buttons, 24'h0);
        chk("wd_k15_connected", 24'(w_connected), 24'h0);
        chk("wd_main_still_conn", 24'(connected), 24'h1);

        // Frame error while timed out still pulses, buttons stay cleared
        shift_bits(5, 24'hFFFFFF);
        latch_edge(1'b0);
        chk("wd_err_pulse", 24'(w_frame_err), 24'h1);
        chk("wd_err_buttons", w_buttons, 24'h0);
        chk("wd_err_connected", 24'(w_connected), 24'h0);
        latch_release();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
